// File: rtl/exc_ctrl.sv
// Exception/interrupt request controller: qualifies retiring traps and the
// external interrupt against CP0 Status and sequences CP0's exception inputs.
module exc_ctrl #(
    parameter logic [4:0] CAUSE_INT     = 5'd0,
    parameter logic [4:0] CAUSE_SYSCALL = 5'd8,
    parameter logic [4:0] CAUSE_BREAK   = 5'd9,
    parameter logic [4:0] CAUSE_TEQ     = 5'd13,
    parameter int         SYNC_STAGES   = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        inst_valid,
    input  logic [31:0] cur_pc,
    input  logic        is_syscall,
    input  logic        is_break,
    input  logic        is_teq,
    input  logic        teq_equal,
    input  logic        is_eret,
    input  logic        ext_irq,
    input  logic        irq_clr,
    input  logic [31:0] status,
    output logic        exception,
    output logic [4:0]  cause,
    output logic [31:0] epc,
    output logic        eret,
    output logic        hold_pc,
    output logic        pc_redirect,
    output logic        irq_pending
);

    typedef enum logic [1:0] {IDLE, RAISE, REDIRECT, ERET} state_t;

    state_t state, next;

    logic [SYNC_STAGES-1:0] sync_q;
    logic        sync_prev;
    logic        pend_q;
    logic        int_q;
    logic [4:0]  cause_q;
    logic [31:0] epc_q;

    logic sys_t, brk_t, teq_t, int_t, eret_t, trap;
    logic irq_rise, hold;
    logic [4:0] new_cause;

    assign sys_t  = inst_valid & is_syscall & status[0] & status[1];
    assign brk_t  = inst_valid & is_break & status[0] & status[2];
    assign teq_t  = inst_valid & is_teq & teq_equal & status[0] & status[3];
    assign int_t  = inst_valid & pend_q & status[0] & status[4];
    assign eret_t = inst_valid & is_eret;
    assign trap   = sys_t | brk_t | teq_t | int_t;

    assign irq_rise = sync_q[SYNC_STAGES-1] & ~sync_prev;

    always_comb begin
        next      = state;
        hold      = 1'b0;
        exception = 1'b0;
        eret      = 1'b0;
        pc_redirect = 1'b0;
        new_cause = CAUSE_INT;
        if (sys_t)      new_cause = CAUSE_SYSCALL;
        else if (brk_t) new_cause = CAUSE_BREAK;
        else if (teq_t) new_cause = CAUSE_TEQ;
        unique case (state)
            IDLE: begin
                hold = eret_t | trap;
                if (eret_t)    next = ERET;
                else if (trap) next = RAISE;
            end
            RAISE: begin
                exception = 1'b1;
                hold      = 1'b1;
                next      = REDIRECT;
            end
            REDIRECT: begin
                pc_redirect = 1'b1;
                next        = IDLE;
            end
            ERET: begin
                eret        = 1'b1;
                pc_redirect = 1'b1;
                next        = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync_q    <= '0;
            sync_prev <= 1'b0;
            pend_q    <= 1'b0;
            int_q     <= 1'b0;
            cause_q   <= '0;
            epc_q     <= '0;
        end else begin
            state     <= next;
            sync_q    <= {sync_q[SYNC_STAGES-2:0], ext_irq};
            sync_prev <= sync_q[SYNC_STAGES-1];
            // A new rising edge outranks any clear in the same cycle
            if (irq_rise)
                pend_q <= 1'b1;
            else if ((state == IDLE && irq_clr) || (state == RAISE && int_q))
                pend_q <= 1'b0;
            if (state == IDLE && !eret_t && trap) begin
                cause_q <= new_cause;
                epc_q   <= cur_pc;
                int_q   <= ~(sys_t | brk_t | teq_t);
            end
        end
    end

    assign hold_pc     = hold & ~rst;
    assign cause       = cause_q;
    assign epc         = epc_q;
    assign irq_pending = pend_q;

endmodule
